// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared state encoding and default sizes for fft_frame_sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_LEN_LOG2_DEF = 10;
  localparam int FFT_DATA_W_DEF   = 18;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_FFT = 2'd2,
    ST_DRAIN    = 2'd3
  } fft_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter; present only with FFT_SEQ_OVERRUN_CNT_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifdef FFT_SEQ_OVERRUN_CNT_EN
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ============================================================================
// fft_frame_sequencer : fills an FFT frame from a sample stream, launches the
// transform and re-times the result stream. Optional FFT_SEQ_OVERRUN_CNT_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int LEN_LOG2 = FFT_LEN_LOG2_DEF,
  parameter int DATA_W   = FFT_DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                fft_ready,
  output logic                fft_load,
  output logic [LEN_LOG2-1:0] fft_load_addr,
  output logic [DATA_W-1:0]   fft_load_data,
  output logic                fft_start,
  input  logic                fft_out_valid,
  input  logic [LEN_LOG2-1:0] fft_out_addr,
  input  logic [DATA_W-1:0]   fft_out_real,
  input  logic [DATA_W-1:0]   fft_out_imag,
  input  logic                fft_done,
  output logic                spec_valid,
  output logic [LEN_LOG2-1:0] spec_bin,
  output logic [DATA_W-1:0]   spec_real,
  output logic [DATA_W-1:0]   spec_imag,
  output logic                frame_done,
  output logic                busy,
  output logic                overrun
`ifdef FFT_SEQ_OVERRUN_CNT_EN
  ,
  output logic [15:0]         overrun_cnt
`endif
);

  localparam logic [LEN_LOG2-1:0] CNT_LAST = {LEN_LOG2{1'b1}};

  // Assertion is asynchronous; release reaches the logic two edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  fft_state_e          state;
  fft_state_e          state_nxt;
  logic [LEN_LOG2-1:0] cnt;
  logic                accept;
  logic                drop;
  logic                capture;

  assign accept  = rst_n && (state == ST_FILL) && sample_valid;
  assign drop    = rst_n && (state != ST_FILL) && sample_valid;
  assign capture = rst_n && ((state == ST_WAIT_FFT) || (state == ST_DRAIN)) && fft_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:     if (sample_valid && (cnt == CNT_LAST)) state_nxt = ST_START;
      ST_START:    if (fft_ready)                         state_nxt = ST_WAIT_FFT;
      ST_WAIT_FFT: if (fft_done)                          state_nxt = ST_DRAIN;
      ST_DRAIN:                                           state_nxt = ST_FILL;
      default:                                            state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    fft_load   = accept;
    fft_start  = rst_n && (state == ST_START) && fft_ready;
    frame_done = (state == ST_DRAIN);
    busy       = (state != ST_FILL);
  end

  assign fft_load_addr = cnt;
  assign fft_load_data = sample_in;

  // The last write of a frame returns cnt to 0 so it never wraps inside FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + LEN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_valid <= 1'b0;
      spec_bin   <= '0;
      spec_real  <= '0;
      spec_imag  <= '0;
    end else begin
      spec_valid <= capture;
      if (capture) begin
        spec_bin  <= fft_out_addr;
        spec_real <= fft_out_real;
        spec_imag <= fft_out_imag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef FFT_SEQ_OVERRUN_CNT_EN
  sat_counter #(
    .W (16)
  ) u_overrun_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (overrun_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ============================================================================
// tb_fft_frame_sequencer : scoreboard bench for fft_frame_sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_sequencer;

  localparam int LEN_LOG2 = 10;
  localparam int DATA_W   = 18;
  localparam int N        = 1 << LEN_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  logic                sample_valid;
  logic [DATA_W-1:0]   sample_in;
  logic                fft_ready;
  logic                fft_load;
  logic [LEN_LOG2-1:0] fft_load_addr;
  logic [DATA_W-1:0]   fft_load_data;
  logic                fft_start;
  logic                fft_out_valid;
  logic [LEN_LOG2-1:0] fft_out_addr;
  logic [DATA_W-1:0]   fft_out_real;
  logic [DATA_W-1:0]   fft_out_imag;
  logic                fft_done;
  logic                spec_valid;
  logic [LEN_LOG2-1:0] spec_bin;
  logic [DATA_W-1:0]   spec_real;
  logic [DATA_W-1:0]   spec_imag;
  logic                frame_done;
  logic                busy;
  logic                overrun;
`ifdef FFT_SEQ_OVERRUN_CNT_EN
  logic [15:0]         overrun_cnt;
`endif

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .LEN_LOG2 (LEN_LOG2),
    .DATA_W   (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .fft_ready     (fft_ready),
    .fft_load      (fft_load),
    .fft_load_addr (fft_load_addr),
    .fft_load_data (fft_load_data),
    .fft_start     (fft_start),
    .fft_out_valid (fft_out_valid),
    .fft_out_addr  (fft_out_addr),
    .fft_out_real  (fft_out_real),
    .fft_out_imag  (fft_out_imag),
    .fft_done      (fft_done),
    .spec_valid    (spec_valid),
    .spec_bin      (spec_bin),
    .spec_real     (spec_real),
    .spec_imag     (spec_imag),
    .frame_done    (frame_done),
    .busy          (busy),
    .overrun       (overrun)
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_cnt   (overrun_cnt)
`endif
  );

  typedef struct {
    logic [LEN_LOG2-1:0] addr;
    logic [DATA_W-1:0]   data;
  } load_t;

  typedef struct {
    logic [LEN_LOG2-1:0] bin;
    logic [DATA_W-1:0]   re;
    logic [DATA_W-1:0]   im;
    int                  at;
  } spec_t;

  load_t load_q[$];
  spec_t spec_q[$];
  load_t le;
  spec_t se;
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int v, input bit expect_load, input int addr);
    sample_valid = 1'b1;
    sample_in    = DATA_W'(v);
    if (expect_load) load_q.push_back('{LEN_LOG2'(addr), DATA_W'(v)});
    step();
  endtask

  task automatic send_bin(input int b, input int re, input int im, input bit done);
    fft_out_valid = 1'b1;
    fft_out_addr  = LEN_LOG2'(b);
    fft_out_real  = DATA_W'(re);
    fft_out_imag  = DATA_W'(im);
    fft_done      = done;
    spec_q.push_back('{LEN_LOG2'(b), DATA_W'(re), DATA_W'(im), cyc + 1});
    step();
    fft_out_valid = 1'b0;
    fft_done      = 1'b0;
  endtask

  // Every observed write must match the next expected one.
  always @(negedge clk) begin
    if (fft_load === 1'b1) begin
      checks++;
      assert (load_q.size() > 0) else begin
        errors++;
        $error("FAIL load_spurious observed addr=%0d expected no write", fft_load_addr);
      end
      if (load_q.size() > 0) begin
        le = load_q.pop_front();
        checks++;
        assert ({fft_load_addr, fft_load_data} === {le.addr, le.data}) else begin
          errors++;
          $error("FAIL load_write observed=%0d/%0h expected=%0d/%0h",
                 fft_load_addr, fft_load_data, le.addr, le.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (spec_valid === 1'b1) begin
      checks++;
      assert (spec_q.size() > 0) else begin
        errors++;
        $error("FAIL spec_spurious observed bin=%0d expected no output", spec_bin);
      end
      if (spec_q.size() > 0) begin
        se = spec_q.pop_front();
        checks++;
        assert ({spec_bin, spec_real, spec_imag} === {se.bin, se.re, se.im} && cyc == se.at) else begin
          errors++;
          $error("FAIL spec_out observed=%0d/%0h/%0h@%0d expected=%0d/%0h/%0h@%0d",
                 spec_bin, spec_real, spec_imag, cyc, se.bin, se.re, se.im, se.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    sample_valid  = 1'b0;
    sample_in     = '0;
    fft_ready     = 1'b1;
    fft_out_valid = 1'b0;
    fft_out_addr  = '0;
    fft_out_real  = '0;
    fft_out_imag  = '0;
    fft_done      = 1'b0;
    repeat (3) step();

    chk("rst_fft_load",   32'(fft_load),   0);
    chk("rst_fft_start",  32'(fft_start),  0);
    chk("rst_spec_valid", 32'(spec_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overrun",    32'(overrun),    0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_spec_bin",   32'(spec_bin),   0);
    chk("rst_spec_real",  32'(spec_real),  0);
    chk("rst_spec_imag",  32'(spec_imag),  0);

    reset = 1'b1;
    repeat (4) step();

    // Results arriving while filling are ignored.
    fft_out_valid = 1'b1;
    fft_out_addr  = 7;
    fft_out_real  = 7;
    fft_done      = 1'b1;
    step();
    fft_out_valid = 1'b0;
    fft_done      = 1'b0;
    chk("fill_ignore_spec", 32'(spec_valid), 0);
    chk("fill_ignore_busy", 32'(busy), 0);

    // Frame 1: ramp samples, ready FFT, coincident last bin and done.
    for (int i = 0; i < N; i++) send_sample(i, 1'b1, i);
    sample_valid = 1'b0;
    #2;
    chk("f1_start_pulse", 32'(fft_start), 1);
    chk("f1_busy_start",  32'(busy), 1);
    chk("f1_no_overrun",  32'(overrun), 0);
    step();
    #2;
    chk("f1_start_once", 32'(fft_start), 0);

    for (int i = 0; i < 5; i++) send_sample(100 + i, 1'b0, 0);
    sample_valid = 1'b0;
    #2;
    chk("drop_overrun", 32'(overrun), 1);
    chk("drop_busy",    32'(busy), 1);
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    chk("drop_overrun_cnt", 32'(overrun_cnt), 5);
`endif

    for (int b = 0; b < N; b++) send_bin(b, b, -b, b == N - 1);
    #2;
    chk("f1_frame_done", 32'(frame_done), 1);
    step();
    #2;
    chk("f1_frame_done_once", 32'(frame_done), 0);
    chk("f1_back_to_fill",    32'(busy), 0);
    chk("f1_overrun_sticky",  32'(overrun), 1);

    // Frame 2: FFT not ready for 20 cycles, stray results while in START.
    fft_ready = 1'b0;
    for (int i = 0; i < N; i++) send_sample(int'($urandom), 1'b1, i);
    sample_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #2;
      chk($sformatf("hold_start_%0d", k), 32'(fft_start), 0);
      fft_out_valid = (k == 10);
      fft_done      = (k == 10);
      step();
      fft_out_valid = 1'b0;
      fft_done      = 1'b0;
    end
    chk("hold_busy", 32'(busy), 1);
    fft_ready = 1'b1;
    #2;
    chk("f2_start_on_ready", 32'(fft_start), 1);
    step();
    #2;
    chk("f2_start_once", 32'(fft_start), 0);

    for (int b = 0; b < 8; b++) send_bin(b * 3, int'($urandom), int'($urandom), 1'b0);
    chk("f2_no_early_done", 32'(frame_done), 0);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    #2;
    chk("f2_frame_done", 32'(frame_done), 1);
    step();
    chk("f2_back_to_fill", 32'(busy), 0);

    // Frame 3: reset after 500 samples discards the partial frame.
    for (int i = 0; i < 500; i++) send_sample(i + 7, 1'b1, i);
    sample_in = 5;
    reset     = 1'b0;
    #1;
    chk("mid_rst_load",     32'(fft_load),   0);
    chk("mid_rst_overrun",  32'(overrun),    0);
    chk("mid_rst_spec_bin", 32'(spec_bin),   0);
    chk("mid_rst_spec_re",  32'(spec_real),  0);
    chk("mid_rst_spec_im",  32'(spec_imag),  0);
    chk("mid_rst_spec_vld", 32'(spec_valid), 0);
    chk("mid_rst_busy",     32'(busy),       0);
    sample_valid = 1'b0;
    step();
    reset = 1'b1;
    repeat (4) step();
    send_sample(12345, 1'b1, 0);
    send_sample(54321, 1'b1, 1);
    sample_valid = 1'b0;
    step();
    step();
    chk("post_rst_overrun", 32'(overrun), 0);

    chk("load_q_empty", 32'(load_q.size()), 0);
    chk("spec_q_empty", 32'(spec_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter LEN_LOG2, default 10, log2 of the FFT frame length N.
REQ-002 SHALL have parameter DATA_W, default 18, sample and spectrum component width.
REQ-003 SHALL have port clk  in  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_valid  in  1  one-cycle strobe: sample_in is valid.
REQ-006 SHALL have port sample_in  in  DATA_W  codec sample, two's complement.
REQ-007 SHALL have port fft_ready  in  1  FFT core idle and able to accept a start.
REQ-008 SHALL have ports fft_load / fft_load_addr / fft_load_data  out  1 / LEN_LOG2 / DATA_W  FFT input-memory write strobe, address and data.
REQ-009 SHALL have port fft_start  out  1  one-cycle pulse that launches the transform.
REQ-010 SHALL have ports fft_out_valid / fft_out_addr / fft_out_real / fft_out_imag  in  1 / LEN_LOG2 / DATA_W / DATA_W  FFT result stream.
REQ-011 SHALL have port fft_done  in  1  one-cycle pulse: FFT finished the frame.
REQ-012 SHALL have ports spec_valid / spec_bin / spec_real / spec_imag  out  1 / LEN_LOG2 / DATA_W / DATA_W  registered spectrum output.
REQ-013 SHALL have ports frame_done  out  1  one-cycle pulse per completed frame; busy  out  1  high in any state other than FILL; overrun  out  1  sticky flag for dropped samples.

Function
REQ-014 SHALL implement the states FILL, START, WAIT_FFT and DRAIN, with FILL as the reset state.
REQ-015 In FILL, each sample_valid SHALL drive fft_load=1, fft_load_addr=cnt and fft_load_data=sample_in in the same cycle (combinational from the registered cnt), then increment cnt.
REQ-016 A sample accepted at cnt==N-1 SHALL transition to START and clear cnt to 0; cnt SHALL never wrap inside FILL.
REQ-017 In START, fft_start SHALL pulse for exactly one cycle, in the first cycle fft_ready=1, then go to WAIT_FFT; with fft_ready=0 the block SHALL hold in START.
REQ-018 In WAIT_FFT and DRAIN, each fft_out_valid SHALL produce spec_valid one cycle later, with spec_bin=fft_out_addr and the real/imag values registered (latency 1).
REQ-019 fft_done SHALL move WAIT_FFT to DRAIN; DRAIN SHALL last exactly one cycle, pulse frame_done, and return to FILL.
REQ-020 If fft_out_valid and fft_done coincide, the final result SHALL still be emitted.
REQ-021 sample_valid outside FILL SHALL be dropped, with no fft_load and overrun set to 1; overrun SHALL stay set until reset.
REQ-022 fft_out_valid and fft_done received in FILL or START SHALL be ignored: no spec_valid and no state change.

Reset
REQ-023 Reset assertion SHALL immediately force state=FILL, cnt=0, and fft_load, fft_start, spec_valid, frame_done and overrun all 0.
REQ-024 Reset SHALL force spec_bin, spec_real and spec_imag to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; the next accepted sample SHALL be written to address 0.
REQ-026 Reset deassertion SHALL be synchronised to clk by a 2-flop synchroniser.

Configuration
REQ-027 With the macro FFT_SEQ_OVERRUN_CNT_EN defined, the block SHALL add output overrun_cnt (16 bits), counting dropped samples, saturating at 16'hFFFF and reset to 0.
REQ-028 Without FFT_SEQ_OVERRUN_CNT_EN, the overrun_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package fft_pkg SHALL hold the state enumeration, FFT_LEN_LOG2_DEF=10 and FFT_DATA_W_DEF=18.
REQ-030 The overrun counter SHALL be a sub-module, sat_counter, instantiated only under the macro; all other logic SHALL be flat.

Verification
REQ-031 Scenario: 1024 consecutive sample_valid with sample_in=addr -> 1024 fft_load writes at addresses 0..1023, then one fft_start pulse in the next cycle.
REQ-032 Scenario: fft_ready held 0 for 20 cycles after the frame fills -> fft_start asserted exactly once, in the cycle fft_ready rises.
REQ-033 Scenario: FFT streams bins 0..1023 with real=bin and imag=-bin -> spec_* identical, delayed 1 cycle; one frame_done pulse follows fft_done.
REQ-034 Scenario: 5 samples during WAIT_FFT -> no fft_load, overrun=1; with the macro, overrun_cnt=5.
REQ-035 Scenario: reset asserted at cnt=500 -> outputs 0 at once; after release, the next sample writes address 0.
REQ-036 Scenario: fft_out_valid (bin 1023) and fft_done in the same cycle -> spec_valid for bin 1023 and frame_done both follow.
